fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the control unit in the VSMP datapath.
- Holds the program counter and the instruction register, and drives the external program memory address.
- Presents the 4-bit opcode to the control unit as INSTR, and drives the operand onto the internal bus when the control unit asserts ENABLEINSTR.
- Steps through the control unit's 4-phase cycle (PHASE 0..3); handles JMP (0110) and HLT (1111) locally.

Parameters:
- AW, 4, program-counter / memory-address width; PC wraps modulo 2^AW.
- DW, 8, instruction word width. Opcode = IR[DW-1:DW-4]; operand = IR[DW-5:0].
- OP_JMP, 4'b0110, opcode that loads PC from the operand.
- OP_HLT, 4'b1111, opcode that freezes fetch.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST  input  1  asynchronous, active-high reset.
- PHASE  input  3  phase from the control unit; only 0..3 are meaningful.
- RUN  input  1  fetch enable; when low, PC, IR and HALTED hold.
- ENABLEINSTR  input  1  from the control unit: drive operand onto the bus.
- MEM_ADDR  output  AW  program memory address; always equals PC.
- MEM_DATA  input  DW  program memory read data; combinational, valid in the same cycle.
- INSTR  output  4  opcode field of IR, to the control unit.
- BUS_OUT  output  DW  operand zero-extended to DW while ENABLEINSTR=1, else all zeros.
- BUS_VALID  output  1  equals ENABLEINSTR.
- HALTED  output  1  high once an HLT instruction has been fetched.
- PC_OUT  output  AW  current PC, for debug.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - PC=0, IR=0 (so INSTR=0000, a no-op in the control unit), HALTED=0.
  - BUS_OUT=0 unless ENABLEINSTR is high.
  - Reset mid-instruction aborts the instruction; no partial PC update survives.
- A posedge counts as "active" only when RUN=1 and HALTED=0. On inactive edges PC and IR hold.
- PHASE 0, active edge: IR <= MEM_DATA (the word at MEM_ADDR=PC).
  - INSTR is therefore stable before the following negedge, when the control unit samples it.
  - If MEM_DATA[DW-1:DW-4]==OP_HLT: HALTED <= 1 in the same edge. PC does not advance afterwards.
- PHASE 1, active edge: PC <= PC+1 modulo 2^AW (0xF -> 0x0 at AW=4).
- PHASE 2, active edge: if IR opcode==OP_JMP, PC <= operand truncated or zero-extended to AW.
  - This overrides the phase-1 increment, so a JMP target is taken exactly and is never target+1.
- PHASE 3, and PHASE values 4..7: no state change.
- HALTED is sticky; only RST clears it. RUN does not clear it.
- An HLT fetched while RUN=1 still sets HALTED.
- BUS_OUT and BUS_VALID are combinational from IR and ENABLEINSTR, with zero latency.
- Fetch latency: the opcode appears on INSTR one posedge after PHASE 0 is entered with RUN=1.
- RUN deassert:
  - During phase 1 or 2, the pending PC update is skipped for that edge and is not replayed.
  - Software restarts on a phase-0 boundary. Verification checks that PC holds, not that the update is recovered.

Decomposition:
- Shared package vsmp_pkg holds:
  - opcode constants: OP_NOP=0000, OP_ADD=0001, OP_SUB=0010, OP_LDA=0101, OP_JMP=0110, OP_HLT=1111;
  - phase constants PH_FETCH=0, PH_INC=1, PH_EXEC=2, PH_WB=3;
  - the default AW and DW.
- One natural sub-module, pc_counter: holds the AW-bit PC with increment, load and hold controls, and asynchronous reset.
- IR and HALTED stay in fetch_unit.

Test Plan:
- Reset: assert RST mid phase 2 with PC=5 -> PC_OUT=0, INSTR=0000 and HALTED=0 immediately, without waiting for a clock edge.
- Sequential fetch: memory[0]=0x13, memory[1]=0x25, PHASE cycled 0..3 twice -> INSTR=0001 then 0010. PC_OUT=1 after the first phase-1 edge and 2 after the second. With ENABLEINSTR=1 in phase 2, BUS_OUT=0x03 then 0x05.
- Jump: memory[2]=0x6A -> after the phase-2 edge PC_OUT=0xA, not 0x3. The next fetch presents the address MEM_ADDR=0xA.
- Wrap: memory[0xF]=0x11, PC=0xF -> after phase 1 PC_OUT=0x0.
- Halt: memory[3]=0xF0 -> HALTED=1 after the phase-0 edge. PC stays 3 through 3 further full phase cycles, and INSTR stays 1111.
- RUN stall: RUN=0 across a full phase 0..3 cycle with PC=4 -> PC_OUT=4 and IR unchanged. With RUN=1 again, the next phase 0 fetches memory[4].

Source files
------------

// File: rtl/vsmp_pkg.sv
// Shared VSMP definitions: opcodes, control-unit phase numbers and default widths.
package vsmp_pkg;

   localparam int AW_DEF = 4;
   localparam int DW_DEF = 8;

   localparam logic [3:0] OP_NOP = 4'b0000;
   localparam logic [3:0] OP_ADD = 4'b0001;
   localparam logic [3:0] OP_SUB = 4'b0010;
   localparam logic [3:0] OP_LDA = 4'b0101;
   localparam logic [3:0] OP_JMP = 4'b0110;
   localparam logic [3:0] OP_HLT = 4'b1111;

   localparam logic [2:0] PH_FETCH = 3'd0;
   localparam logic [2:0] PH_INC   = 3'd1;
   localparam logic [2:0] PH_EXEC  = 3'd2;
   localparam logic [2:0] PH_WB    = 3'd3;

endpackage

// File: rtl/fetch_unit_pc_counter.sv
// Program counter: AW-bit register with load (priority), increment and hold.
module pc_counter #(
   parameter int AW = 4
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic          inc,
   input  logic          load,
   input  logic [AW-1:0] load_val,
   output logic [AW-1:0] pc
);

   logic [AW-1:0] pc_reg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pc_reg <= '0;
      end else if (load) begin
         pc_reg <= load_val;
      end else if (inc) begin
         pc_reg <= pc_reg + AW'(1);
      end
   end

   assign pc = pc_reg;

endmodule

// File: rtl/fetch_unit.sv
// VSMP instruction fetch: owns PC and IR, feeds the opcode to the control unit,
// resolves JMP in phase 2 and freezes on HLT until reset.
module fetch_unit
   import vsmp_pkg::*;
#(
   parameter int         AW     = AW_DEF,
   parameter int         DW     = DW_DEF,
   parameter logic [3:0] OP_JMP = vsmp_pkg::OP_JMP,
   parameter logic [3:0] OP_HLT = vsmp_pkg::OP_HLT
) (
   input  logic          CLK,
   input  logic          RST,
   input  logic [2:0]    PHASE,
   input  logic          RUN,
   input  logic          ENABLEINSTR,
   output logic [AW-1:0] MEM_ADDR,
   input  logic [DW-1:0] MEM_DATA,
   output logic [3:0]    INSTR,
   output logic [DW-1:0] BUS_OUT,
   output logic          BUS_VALID,
   output logic          HALTED,
   output logic [AW-1:0] PC_OUT
);

   localparam int OPW = DW - 4;

   logic [DW-1:0]  ir_reg;
   logic           halted_reg;
   logic           active;
   logic [3:0]     opcode;
   logic [OPW-1:0] operand;
   logic [AW-1:0]  jump_target;
   logic           pc_inc;
   logic           pc_load;
   logic [AW-1:0]  pc;

   assign active  = RUN && !halted_reg;
   assign opcode  = ir_reg[DW-1:DW-4];
   assign operand = ir_reg[OPW-1:0];

   // Operand is fitted to the PC width so JMP lands exactly on the target.
   generate
      if (OPW >= AW) begin : g_trunc
         assign jump_target = operand[AW-1:0];
      end else begin : g_zext
         assign jump_target = {{(AW-OPW){1'b0}}, operand};
      end
   endgenerate

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ir_reg     <= '0;
         halted_reg <= 1'b0;
      end else if (active && PHASE == PH_FETCH) begin
         ir_reg <= MEM_DATA;
         if (MEM_DATA[DW-1:DW-4] == OP_HLT) begin
            halted_reg <= 1'b1;
         end
      end
   end

   // Load has priority inside the counter, but phases never overlap anyway.
   assign pc_inc  = active && PHASE == PH_INC;
   assign pc_load = active && PHASE == PH_EXEC && opcode == OP_JMP;

   pc_counter #(.AW(AW)) u_pc (
      .CLK      (CLK),
      .RST      (RST),
      .inc      (pc_inc),
      .load     (pc_load),
      .load_val (jump_target),
      .pc       (pc)
   );

   assign MEM_ADDR  = pc;
   assign PC_OUT    = pc;
   assign INSTR     = opcode;
   assign HALTED    = halted_reg;
   assign BUS_VALID = ENABLEINSTR;
   assign BUS_OUT   = ENABLEINSTR ? {4'b0000, operand} : '0;

endmodule
